// File: rtl/l1_i_controller.sv
// L1 instruction cache controller: 2-way set-associative, read-only tag store with
// per-set LRU, a four-state miss FSM and an edge-triggered invalidate-all (flush).
// The data array lives outside; it follows `refill` and `way`.
module l1_i_controller #(
  parameter int unsigned TNUM = 21,
  parameter int unsigned INUM = 26 - TNUM
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [TNUM-1:0] tag_C_L1,
  input  logic [INUM-1:0] index_C_L1,
  input  logic            read_C_L1,
  input  logic            flush,
  input  logic            ready_L2_L1,
  output logic            stall,
  output logic            refill,
  output logic            way,
  output logic            read_L1_L2,
  output logic [INUM-1:0] index_L1_L2,
  output logic [TNUM-1:0] tag_L1_L2
);

  localparam int unsigned Sets = 1 << INUM;

  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StAllocate,
    StRefill
  } state_e;

  state_e state_q;

  // Tag store: per-set valid pair, tags per way, one LRU bit naming the older way.
  logic [1:0]      valid_q [Sets];
  logic [TNUM-1:0] tag_mem [2][Sets];
  logic [Sets-1:0] lru_q;

  logic victim_q;
  logic read_q;
  logic refill_q;
  logic flush_q;

  logic       flush_rise;
  logic [1:0] set_valid;
  logic       hit0;
  logic       hit1;
  logic       hit;
  logic       hit_way;
  logic       victim;

  assign flush_rise = flush & ~flush_q;

  // Combinational lookup of the core request against both ways of the addressed set.
  always_comb begin
    set_valid = valid_q[index_C_L1];
    hit0      = set_valid[0] && (tag_mem[0][index_C_L1] == tag_C_L1);
    hit1      = set_valid[1] && (tag_mem[1][index_C_L1] == tag_C_L1);
    hit       = hit0 | hit1;
    hit_way   = ~hit0;
    // Fill empty ways first, in order; only evict by LRU once the set is full.
    if (!set_valid[0]) begin
      victim = 1'b0;
    end else if (!set_valid[1]) begin
      victim = 1'b1;
    end else begin
      victim = lru_q[index_C_L1];
    end
  end

  // Miss FSM together with valid/LRU state and the registered L2-side outputs.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q     <= StIdle;
      lru_q       <= '0;
      victim_q    <= 1'b0;
      read_q      <= 1'b0;
      refill_q    <= 1'b0;
      flush_q     <= 1'b0;
      index_L1_L2 <= '0;
      tag_L1_L2   <= '0;
      for (int unsigned s = 0; s < Sets; s++) begin
        valid_q[s] <= 2'b00;
      end
    end else begin
      flush_q <= flush;
      if (flush_rise) begin
        // Invalidate everything once per flush edge and drop any miss in flight.
        state_q  <= StIdle;
        lru_q    <= '0;
        read_q   <= 1'b0;
        refill_q <= 1'b0;
        for (int unsigned s = 0; s < Sets; s++) begin
          valid_q[s] <= 2'b00;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (read_C_L1) begin
              state_q <= StCompare;
            end
          end
          StCompare: begin
            if (!read_C_L1) begin
              state_q <= StIdle;
            end else if (hit) begin
              lru_q[index_C_L1] <= ~hit_way;
            end else begin
              index_L1_L2 <= index_C_L1;
              tag_L1_L2   <= tag_C_L1;
              victim_q    <= victim;
              read_q      <= 1'b1;
              state_q     <= StAllocate;
            end
          end
          StAllocate: begin
            if (ready_L2_L1) begin
              read_q   <= 1'b0;
              refill_q <= 1'b1;
              state_q  <= StRefill;
            end
          end
          StRefill: begin
            valid_q[index_L1_L2][victim_q] <= 1'b1;
            lru_q[index_L1_L2]             <= ~victim_q;
            refill_q                       <= 1'b0;
            state_q                        <= StCompare;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  // Tag write at the end of the refill cycle; no reset needed since valid bits gate use.
  always_ff @(posedge clk) begin
    if (!nrst && !flush_rise && (state_q == StRefill)) begin
      tag_mem[victim_q][index_L1_L2] <= tag_L1_L2;
    end
  end

  // Core-side handshake: stall must drop in the same cycle as a hit, so it is decoded.
  always_comb begin
    stall = 1'b0;
    way   = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = 1'b0;
      end
      StCompare: begin
        if (read_C_L1) begin
          if (hit) begin
            way = hit_way;
          end else begin
            stall = 1'b1;
            way   = victim;
          end
        end
      end
      StAllocate, StRefill: begin
        stall = 1'b1;
        way   = victim_q;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign refill     = refill_q;
  assign read_L1_L2 = read_q;

endmodule

// File: tb/tb_l1_i_controller.sv
// Self-checking bench for l1_i_controller: a reference tag-store model predicts hit/way
// for each request, predictions queue up as stimulus is driven and are compared when the
// DUT presents its lookup result.
module tb_l1_i_controller;

  localparam int unsigned TNUM = 21;
  localparam int unsigned INUM = 5;
  localparam int unsigned SETS = 32;

  typedef struct packed {
    logic            hit;
    logic            way;
    logic [TNUM-1:0] tag;
    logic [INUM-1:0] idx;
  } exp_t;

  logic            clk = 1'b0;
  logic            nrst;
  logic [TNUM-1:0] tag_c;
  logic [INUM-1:0] idx_c;
  logic            read_c;
  logic            flush;
  logic            ready;
  logic            stall;
  logic            refill;
  logic            way;
  logic            read_L1_L2;
  logic [INUM-1:0] index_L1_L2;
  logic [TNUM-1:0] tag_L1_L2;

  int vectors = 0;
  int miscompares = 0;
  int refill_cnt = 0;

  exp_t sb[$];

  // Reference model state
  logic            mvalid [2][SETS];
  logic [TNUM-1:0] mtag   [2][SETS];
  logic            mlru   [SETS];
  logic [TNUM-1:0] rt     [2][SETS];

  l1_i_controller #(
    .TNUM(TNUM),
    .INUM(INUM)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .tag_C_L1   (tag_c),
    .index_C_L1 (idx_c),
    .read_C_L1  (read_c),
    .flush      (flush),
    .ready_L2_L1(ready),
    .stall      (stall),
    .refill     (refill),
    .way        (way),
    .read_L1_L2 (read_L1_L2),
    .index_L1_L2(index_L1_L2),
    .tag_L1_L2  (tag_L1_L2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (refill === 1'b1) refill_cnt <= refill_cnt + 1;
  end

  function automatic void clear_model();
    for (int s = 0; s < int'(SETS); s++) begin
      mvalid[0][s] = 1'b0;
      mvalid[1][s] = 1'b0;
      mlru[s]      = 1'b0;
    end
  endfunction

  function automatic exp_t predict(input logic [TNUM-1:0] t, input logic [INUM-1:0] i);
    exp_t e;
    e.tag = t;
    e.idx = i;
    if (mvalid[0][i] && mtag[0][i] == t) begin
      e.hit = 1'b1;
      e.way = 1'b0;
    end else if (mvalid[1][i] && mtag[1][i] == t) begin
      e.hit = 1'b1;
      e.way = 1'b1;
    end else begin
      e.hit = 1'b0;
      if (!mvalid[0][i]) e.way = 1'b0;
      else if (!mvalid[1][i]) e.way = 1'b1;
      else e.way = mlru[i];
      mvalid[e.way][i] = 1'b1;
      mtag[e.way][i]   = t;
    end
    mlru[i] = ~e.way;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b1;
    read_c = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    clear_model();
    @(negedge clk);
  endtask

  // One complete request: lookup, and on a miss the L2 handshake with dly wait cycles.
  task automatic access(input logic [TNUM-1:0] t, input logic [INUM-1:0] i, input int dly,
                        input int want_way);
    exp_t e;
    int   pulses;
    logic hold_ok;
    sb.push_back(predict(t, i));
    @(negedge clk);
    tag_c = t; idx_c = i; read_c = 1'b1;
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if (stall !== !e.hit) begin
      miscompares++;
      $display("FAIL lookup_stall tag=%h idx=%0d: got %b want %b", t, i, stall, !e.hit);
    end
    vectors++;
    if (way !== e.way) begin
      miscompares++;
      $display("FAIL lookup_way tag=%h idx=%0d: got %b want %b", t, i, way, e.way);
    end
    if (want_way >= 0) begin
      vectors++;
      if (way !== want_way[0]) begin
        miscompares++;
        $display("FAIL expected_way tag=%h idx=%0d: got %b want %0d", t, i, way, want_way);
      end
    end
    if (e.hit) begin
      vectors++;
      if (read_L1_L2 !== 1'b0 || refill !== 1'b0) begin
        miscompares++;
        $display("FAIL hit_no_l2 tag=%h: got rd=%b rf=%b want 0 0", t, read_L1_L2, refill);
      end
    end else begin
      pulses = refill_cnt;
      @(posedge clk); #1;
      vectors++;
      if ({stall, read_L1_L2, refill} !== 3'b110) begin
        miscompares++;
        $display("FAIL allocate_ctl: got stall/rd/rf=%b%b%b want 110", stall, read_L1_L2, refill);
      end
      vectors++;
      if (index_L1_L2 !== i || tag_L1_L2 !== t) begin
        miscompares++;
        $display("FAIL miss_addr: got idx=%0d tag=%h want idx=%0d tag=%h",
                 index_L1_L2, tag_L1_L2, i, t);
      end
      hold_ok = 1'b1;
      for (int c = 0; c < dly; c++) begin
        @(posedge clk); #1;
        if (stall !== 1'b1 || read_L1_L2 !== 1'b1 || refill !== 1'b0) hold_ok = 1'b0;
      end
      if (dly > 0) begin
        vectors++;
        if (hold_ok !== 1'b1) begin
          miscompares++;
          $display("FAIL allocate_hold dly=%0d: got held=%b want 1", dly, hold_ok);
        end
      end
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      vectors++;
      if ({stall, read_L1_L2, refill, way} !== {3'b101, e.way}) begin
        miscompares++;
        $display("FAIL refill_ctl: got stall/rd/rf/way=%b%b%b%b want 101%b",
                 stall, read_L1_L2, refill, way, e.way);
      end
      @(posedge clk); #1;
      vectors++;
      if (stall !== 1'b0 || way !== e.way || refill !== 1'b0) begin
        miscompares++;
        $display("FAIL relookup: got stall=%b way=%b rf=%b want 0 %b 0", stall, way, refill, e.way);
      end
      vectors++;
      if (refill_cnt - pulses !== 1) begin
        miscompares++;
        $display("FAIL refill_pulses: got %0d want 1", refill_cnt - pulses);
      end
    end
    @(posedge clk); #1;
    read_c = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({stall, refill, way, read_L1_L2} !== 4'b0000 || index_L1_L2 !== '0 || tag_L1_L2 !== '0)
    begin
      miscompares++;
      $display("FAIL reset_outputs: got s/rf/w/rd=%b%b%b%b idx=%0d tag=%h want all zero",
               stall, refill, way, read_L1_L2, index_L1_L2, tag_L1_L2);
    end
    read_c = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (stall !== 1'b0 || read_L1_L2 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: got stall=%b rd=%b want 0 0", stall, read_L1_L2);
    end
    read_c = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    clear_model();
  endtask

  task automatic test_cold_fill();
    access(21'h12345, 5'd3, 0, 0);
    access(21'h0ABCD, 5'd3, 0, 1);
    access(21'h12345, 5'd3, 0, 0);
    access(21'h0ABCD, 5'd3, 0, 1);
    vectors++;
    if (tag_L1_L2 !== 21'h0ABCD || index_L1_L2 !== 5'd3) begin
      miscompares++;
      $display("FAIL miss_addr_hold: got tag=%h idx=%0d want 0abcd 3", tag_L1_L2, index_L1_L2);
    end
  endtask

  task automatic test_replace();
    access(21'h12345, 5'd3, 0, 0);
    access(21'h1FFFF, 5'd3, 0, 1);
    access(21'h00042, 5'd3, 0, 0);
  endtask

  task automatic test_delayed_l2();
    access(21'h05555, 5'd9, 12, 0);
    access(21'h05555, 5'd9, 0, 0);
  endtask

  task automatic test_reset_mid_miss();
    exp_t e;
    sb.push_back(predict(21'h0F0F0, 5'd17));
    @(negedge clk);
    tag_c = 21'h0F0F0; idx_c = 5'd17; read_c = 1'b1;
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if (stall !== !e.hit) begin
      miscompares++;
      $display("FAIL rst_miss_stall: got %b want %b", stall, !e.hit);
    end
    @(posedge clk); #1;
    vectors++;
    if (read_L1_L2 !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_miss_alloc: got rd=%b want 1", read_L1_L2);
    end
    #1;
    nrst = 1'b1;
    #1;
    vectors++;
    if ({stall, refill, way, read_L1_L2} !== 4'b0000 || index_L1_L2 !== '0 || tag_L1_L2 !== '0)
    begin
      miscompares++;
      $display("FAIL rst_async: got s/rf/w/rd=%b%b%b%b idx=%0d tag=%h want all zero",
               stall, refill, way, read_L1_L2, index_L1_L2, tag_L1_L2);
    end
    read_c = 1'b0;
    ready  = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    nrst  = 1'b0;
    clear_model();
    access(21'h0F0F0, 5'd17, 0, 0);
  endtask

  task automatic test_fill();
    do_reset();
    for (int s = 0; s < int'(SETS); s++) begin
      rt[0][s] = TNUM'($urandom);
      rt[1][s] = ~rt[0][s];
      access(rt[0][s], INUM'(s), 0, 0);
      access(rt[1][s], INUM'(s), 0, 1);
    end
  endtask

  // Re-read every filled line with read held high: one lookup per cycle, no refills.
  task automatic test_back_to_back();
    exp_t e;
    int   pulses;
    pulses = refill_cnt;
    for (int k = 0; k < 2 * int'(SETS); k++) begin
      sb.push_back(predict(rt[k % 2][k / 2], INUM'(k / 2)));
    end
    @(negedge clk);
    tag_c = rt[0][0]; idx_c = '0; read_c = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2 * int'(SETS); k++) begin
      e = sb.pop_front();
      vectors++;
      if (stall !== 1'b0 || way !== e.way || read_L1_L2 !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_hit tag=%h idx=%0d: got stall=%b way=%b rd=%b want 0 %b 0",
                 e.tag, e.idx, stall, way, read_L1_L2, e.way);
      end
      if (k + 1 < 2 * int'(SETS)) begin
        tag_c = rt[(k + 1) % 2][(k + 1) / 2];
        idx_c = INUM'((k + 1) / 2);
      end
      @(posedge clk); #1;
    end
    read_c = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (refill_cnt != pulses) begin
      miscompares++;
      $display("FAIL b2b_refills: got %0d want 0", refill_cnt - pulses);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    clear_model();
    for (int s = 0; s < 4; s++) access(rt[0][s], INUM'(s), 0, 0);
    for (int s = 0; s < 4; s++) access(rt[0][s], INUM'(s), 0, 0);
    access(rt[1][2], 5'd2, 0, 1);
    access(rt[1][2], 5'd2, 0, 1);
    @(negedge clk);
    flush = 1'b0;
    // Flush edge while a miss is waiting on L2: the miss is abandoned.
    sb.push_back(predict(21'h13579, 5'd30));
    @(negedge clk);
    tag_c = 21'h13579; idx_c = 5'd30; read_c = 1'b1;
    @(posedge clk); #1;
    e = sb.pop_front();
    @(posedge clk); #1;
    flush = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    read_c = 1'b0;
    ready  = 1'b0;
    clear_model();
    vectors++;
    if ({stall, refill, read_L1_L2} !== 3'b000) begin
      miscompares++;
      $display("FAIL flush_abort tag=%h: got s/rf/rd=%b%b%b want 000",
               e.tag, stall, refill, read_L1_L2);
    end
    @(negedge clk);
    flush = 1'b0;
    access(rt[0][0], 5'd0, 0, 0);
    access(21'h13579, 5'd30, 0, 0);
  endtask

  initial begin
    nrst   = 1'b1;
    tag_c  = '0;
    idx_c  = '0;
    read_c = 1'b0;
    flush  = 1'b0;
    ready  = 1'b0;
    clear_model();
    test_reset();
    test_cold_fill();
    test_replace();
    test_delayed_l2();
    test_reset_mid_miss();
    test_fill();
    test_back_to_back();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
